// File: rtl/alu_arb_pkg.sv
// ---------------------------------------------------------------------------
// alu_arb_pkg
// Shared definitions for the ALU arbiter slice.
// Contents:
//   - the `ALUOP_WIDTH macro;
//   - the datapath width and opcode width;
//   - the aluop_t opcode type;
//   - the named ALU opcodes.
// No ports.
// ---------------------------------------------------------------------------
`ifndef ALUOP_WIDTH
`define ALUOP_WIDTH 5
`endif

package alu_arb_pkg;

    localparam int DATA_W  = 64;
    localparam int ALUOP_W = `ALUOP_WIDTH;

    typedef logic [ALUOP_W-1:0] aluop_t;

    localparam aluop_t ALU_ADD   = aluop_t'(0);
    localparam aluop_t ALU_SUB   = aluop_t'(1);
    localparam aluop_t ALU_AND   = aluop_t'(2);
    localparam aluop_t ALU_OR    = aluop_t'(3);
    localparam aluop_t ALU_XOR   = aluop_t'(4);
    localparam aluop_t ALU_SLT   = aluop_t'(5);
    localparam aluop_t ALU_SLTU  = aluop_t'(6);
    localparam aluop_t ALU_SLL   = aluop_t'(7);
    localparam aluop_t ALU_SRL   = aluop_t'(8);
    localparam aluop_t ALU_SRA   = aluop_t'(9);
    localparam aluop_t ALU_ADDW  = aluop_t'(10);
    localparam aluop_t ALU_SUBW  = aluop_t'(11);
    localparam aluop_t ALU_SLLW  = aluop_t'(12);
    localparam aluop_t ALU_SRLW  = aluop_t'(13);
    localparam aluop_t ALU_SRAW  = aluop_t'(14);
    localparam aluop_t ALU_PASSB = aluop_t'(20);
    localparam aluop_t ALU_LINK  = aluop_t'(21);

endpackage

// File: rtl/alu_arb_if.sv
// ---------------------------------------------------------------------------
// alu_arb_if
// Request/response bundle between the requesters and the ALU arbiter.
//
// Request side: one lane per requester, with lane i at bits [W*i +: W].
//   req_valid, req_ready
//   req_a, req_b, req_op, req_tag
//
// Response side: a single registered channel.
//   rsp_valid, rsp_ready
//   rsp_id, rsp_tag, rsp_data
//
// Modports:
//   slave  - the arbiter.
//   master - the requesters and the response consumer.
// ---------------------------------------------------------------------------
interface alu_arb_if #(
    parameter int NREQ  = 2,
    parameter int TAG_W = 4
) ();
    import alu_arb_pkg::*;

    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*DATA_W-1:0]  req_a;
    logic [NREQ*DATA_W-1:0]  req_b;
    logic [NREQ*ALUOP_W-1:0] req_op;
    logic [NREQ*TAG_W-1:0]   req_tag;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [TAG_W-1:0]        rsp_tag;
    logic [DATA_W-1:0]       rsp_data;

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_tag, rsp_data
    );

    modport master (
        output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_tag, rsp_data
    );
endinterface

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Combinational 64-bit integer ALU.
//   - W ops work on the low 32 bits and sign-extend bit 31 of the result.
//   - Shift amounts are b[5:0], or b[4:0] for the W ops.
//   - Unknown opcodes give 0.
//
// Ports:
//   a  in  64       operand A
//   b  in  64       operand B
//   op in  ALUOP_W  opcode
//   y  out 64       result
// ---------------------------------------------------------------------------
module alu import alu_arb_pkg::*; (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  aluop_t            op,
    output logic [DATA_W-1:0] y
);
    function automatic logic [DATA_W-1:0] sext32(input logic [31:0] v);
        return {{(DATA_W-32){v[31]}}, v};
    endfunction

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic signed [31:0]       aw_s;

    assign a_s  = a;
    assign b_s  = b;
    assign aw_s = a[31:0];

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_SLT:   y = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU:  y = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_SLL:   y = a << b[5:0];
            ALU_SRL:   y = a >> b[5:0];
            ALU_SRA:   y = a_s >>> b[5:0];
            ALU_ADDW:  y = sext32(a[31:0] + b[31:0]);
            ALU_SUBW:  y = sext32(a[31:0] - b[31:0]);
            ALU_SLLW:  y = sext32(a[31:0] << b[4:0]);
            ALU_SRLW:  y = sext32(a[31:0] >> b[4:0]);
            ALU_SRAW:  y = sext32(aw_s >>> b[4:0]);
            ALU_PASSB: y = b;
            ALU_LINK:  y = b + DATA_W'(4);
            default:   y = '0;
        endcase
    end
endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick.
// The search starts at (last+1) mod N and wraps around.
// The first requesting index found wins.
//
// Ports:
//   req     in  N   request vector
//   last    in  IW  index granted most recently
//   gnt_idx out IW  winning index (0 when gnt_any=0)
//   gnt_any out 1   at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);
    int idx;

    // Walk from the farthest candidate back to the nearest one.
    // The closest requester after 'last' is therefore written last and wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req[IW'(idx)]) begin
                gnt_idx = IW'(idx);
                gnt_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_arb.sv
// ---------------------------------------------------------------------------
// alu_arb
// Shares one ALU between NREQ requesters.
//   - Round-robin arbitration picks a requester.
//   - The response is registered, giving one-cycle latency.
//   - Back-to-back issue is possible whenever the response is consumed.
//
// Ports:
//   clk   in  clock
//   reset in  synchronous, active-high
//   bus   alu_arb_if.slave; carries the request lanes and the response channel
// ---------------------------------------------------------------------------
module alu_arb import alu_arb_pkg::*; #(
    parameter int NREQ  = 2,
    parameter int TAG_W = 4
) (
    input  logic     clk,
    input  logic     reset,
    alu_arb_if.slave bus
);
    localparam int ID_W = $clog2(NREQ);

    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              can_issue;
    logic              accept;
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;
    aluop_t            op_p0;
    logic [TAG_W-1:0]  tag_p0;
    logic [DATA_W-1:0] y_p0;

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic [ID_W-1:0]   id_p1;
    logic [TAG_W-1:0]  tag_p1;
    logic [ID_W-1:0]   last_p1;

    // Stage p0: arbitration, operand mux and ALU
    rr_arbiter #(.N(NREQ), .IW(ID_W)) u_rr (
        .req     (bus.req_valid),
        .last    (last_p1),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Ready is withheld during reset.
    // A requester therefore never sees a handshake that the reset edge discards.
    assign can_issue = !reset && (!vld_p1 || bus.rsp_ready);
    assign accept    = gnt_any && can_issue;

    always_comb begin
        bus.req_ready = '0;
        a_p0          = '0;
        b_p0          = '0;
        op_p0         = '0;
        tag_p0        = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(gnt_idx) == i) begin
                bus.req_ready[i] = accept;
                a_p0             = bus.req_a[i*DATA_W +: DATA_W];
                b_p0             = bus.req_b[i*DATA_W +: DATA_W];
                op_p0            = bus.req_op[i*ALUOP_W +: ALUOP_W];
                tag_p0           = bus.req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    alu u_alu (
        .a  (a_p0),
        .b  (b_p0),
        .op (op_p0),
        .y  (y_p0)
    );

    // Stage p1: response register
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            id_p1   <= '0;
            tag_p1  <= '0;
            last_p1 <= ID_W'(NREQ - 1);
        end else if (accept) begin
            vld_p1  <= 1'b1;
            data_p1 <= y_p0;
            id_p1   <= gnt_idx;
            tag_p1  <= tag_p0;
            last_p1 <= gnt_idx;
        end else if (vld_p1 && bus.rsp_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign bus.rsp_valid = vld_p1;
    assign bus.rsp_data  = data_p1;
    assign bus.rsp_id    = id_p1;
    assign bus.rsp_tag   = tag_p1;
endmodule
